// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK].
// Optional macro SEQ_ILLEGAL_TRAP_EN: unrecognised opcodes latch o_illegal and park in TRAP.
module multicycle_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            o_imem_req,
  input  logic            i_imem_valid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_instr,
  output logic            o_pc_wen,
  output logic            o_calc_bj_addr,
  output logic            o_jalr_sel,
  output logic            o_imm_sel,
  output logic [3:0]      o_alu_op,
  input  logic            i_alu_z,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  input  logic            i_dmem_ready,
  output logic            o_rf_wen,
  output logic [1:0]      o_wb_sel,
  output logic            o_retire,
  output logic            o_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP} state_t;
  typedef enum logic [3:0] {
    CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR,
    CL_LUI, CL_AUIPC, CL_SYS, CL_BAD
  } cls_t;

  state_t state;
  cls_t   cls;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       f7b5;
  logic       taken;

  assign opcode = o_instr[6:0];
  assign funct3 = o_instr[14:12];
  assign rd     = o_instr[11:7];
  assign f7b5   = o_instr[30];
  // Zero flag polarity flips for BNE/BLT/BLTU (funct3 bit0 xor bit2).
  assign taken  = i_alu_z ^ funct3[0] ^ funct3[2];

  cls_t       dec_cls;
  logic [3:0] dec_alu_op;
  logic       dec_imm_sel;
  logic [1:0] dec_wb_sel;

  always_comb begin
    dec_cls     = CL_SYS;
    dec_alu_op  = '0;
    dec_imm_sel = 1'b0;
    dec_wb_sel  = 2'd0;
    case (opcode)
      OPC_OP: begin
        dec_cls    = CL_OP;
        dec_alu_op = {f7b5, funct3};
      end
      OPC_OPIMM: begin
        dec_cls     = CL_OPIMM;
        dec_alu_op  = {(funct3 == 3'b101) & f7b5, funct3};
        dec_imm_sel = 1'b1;
      end
      OPC_LOAD: begin
        dec_cls     = CL_LOAD;
        dec_imm_sel = 1'b1;
        dec_wb_sel  = 2'd1;
      end
      OPC_STORE: begin
        dec_cls     = CL_STORE;
        dec_imm_sel = 1'b1;
      end
      OPC_BRANCH: begin
        dec_cls    = CL_BRANCH;
        dec_alu_op = funct3[2] ? (funct3[1] ? 4'b0011 : 4'b0010) : 4'b1000;
      end
      OPC_JAL: begin
        dec_cls    = CL_JAL;
        dec_wb_sel = 2'd2;
      end
      OPC_JALR: begin
        dec_cls     = CL_JALR;
        dec_imm_sel = 1'b1;
        dec_wb_sel  = 2'd2;
      end
      OPC_LUI: begin
        dec_cls     = CL_LUI;
        dec_imm_sel = 1'b1;
        dec_wb_sel  = 2'd3;
      end
      OPC_AUIPC: begin
        dec_cls     = CL_AUIPC;
        dec_imm_sel = 1'b1;
      end
      OPC_SYSTEM, OPC_FENCE: dec_cls = CL_SYS;
`ifdef SEQ_ILLEGAL_TRAP_EN
      default: dec_cls = CL_BAD;
`else
      default: dec_cls = CL_SYS;
`endif
    endcase
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign o_illegal = illegal_q;
`else
  assign o_illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= FETCH;
      cls        <= CL_SYS;
      o_instr    <= NOP_INSTR;
      o_alu_op   <= '0;
      o_imm_sel  <= 1'b0;
      o_wb_sel   <= '0;
      o_imem_req <= 1'b1;
      o_dmem_req <= 1'b0;
      o_dmem_we  <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (i_imem_valid) begin
            o_instr    <= i_imem_rdata;
            o_imem_req <= 1'b0;
            state      <= DECODE;
          end
        end
        DECODE: begin
          cls       <= dec_cls;
          o_alu_op  <= dec_alu_op;
          o_imm_sel <= dec_imm_sel;
          o_wb_sel  <= dec_wb_sel;
`ifdef SEQ_ILLEGAL_TRAP_EN
          if (dec_cls == CL_BAD) begin
            illegal_q <= 1'b1;
            state     <= TRAP;
          end else begin
            state <= EXECUTE;
          end
`else
          state <= EXECUTE;
`endif
        end
        EXECUTE: begin
          case (cls)
            CL_BRANCH, CL_SYS: begin
              o_imem_req <= 1'b1;
              state      <= FETCH;
            end
            CL_LOAD, CL_STORE: begin
              o_dmem_req <= 1'b1;
              o_dmem_we  <= (cls == CL_STORE);
              state      <= MEMORY;
            end
            default: state <= WRITEBACK;
          endcase
        end
        MEMORY: begin
          if (i_dmem_ready) begin
            o_dmem_req <= 1'b0;
            o_dmem_we  <= 1'b0;
            if (cls == CL_STORE) begin
              o_imem_req <= 1'b1;
              state      <= FETCH;
            end else begin
              state <= WRITEBACK;
            end
          end
        end
        WRITEBACK: begin
          o_imem_req <= 1'b1;
          state      <= FETCH;
        end
        TRAP: state <= TRAP;
        default: begin
          o_imem_req <= 1'b1;
          state      <= FETCH;
        end
      endcase
    end
  end

  // Strobes depend on same-cycle ALU zero / dmem ready, so they are decoded
  // from the state register and masked while reset is asserted.
  logic pc_wen;
  always_comb begin
    pc_wen         = 1'b0;
    o_rf_wen       = 1'b0;
    o_calc_bj_addr = 1'b0;
    o_jalr_sel     = 1'b0;
    case (state)
      EXECUTE: begin
        if (cls == CL_BRANCH || cls == CL_SYS) pc_wen = 1'b1;
        if (cls == CL_BRANCH) o_calc_bj_addr = taken;
      end
      MEMORY: pc_wen = (cls == CL_STORE) && i_dmem_ready;
      WRITEBACK: begin
        pc_wen         = 1'b1;
        o_rf_wen       = rstn && (rd != 5'd0);
        o_calc_bj_addr = (cls == CL_JAL);
        o_jalr_sel     = (cls == CL_JALR);
      end
      default: pc_wen = 1'b0;
    endcase
  end

  assign o_pc_wen = pc_wen && rstn;
  assign o_retire = pc_wen && rstn;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: a per-instruction cycle-trace model feeds a queue that
// drives inputs and holds the expected outputs for every cycle.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        alu_z = 1'b0;
  logic        dmem_ready = 1'b0;

  logic        imem_req, pc_wen, calc_bj_addr, jalr_sel, imm_sel;
  logic        dmem_req, dmem_we, rf_wen, retire, illegal;
  logic [31:0] instr;
  logic [3:0]  alu_op;
  logic [1:0]  wb_sel;

  multicycle_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .o_imem_req(imem_req), .i_imem_valid(imem_valid), .i_imem_rdata(imem_rdata),
    .o_instr(instr), .o_pc_wen(pc_wen), .o_calc_bj_addr(calc_bj_addr),
    .o_jalr_sel(jalr_sel), .o_imm_sel(imm_sel), .o_alu_op(alu_op), .i_alu_z(alu_z),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .i_dmem_ready(dmem_ready),
    .o_rf_wen(rf_wen), .o_wb_sel(wb_sel), .o_retire(retire), .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          rstn, valid, ready, z;
    logic [31:0] rdata;
    bit          imem_req, dmem_req, dmem_we, pc_wen, rf_wen, retire, calc, jalr, imm_sel, illegal;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
    logic [31:0] instr;
    bit          c_rst, c_rstval, c_instr, c_alu, c_imm, c_wb, c_fin;
  } cyc_t;

  cyc_t  plan[$];
  cyc_t  cur;
  bit    cur_ok = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;
  string stage = "model";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%s] t=%0t: got 0x%0h, expected 0x%0h", name, stage, $time, act, exp);
    end
  endtask

  function automatic cyc_t blank(input string tag);
    cyc_t e;
    e.tag = tag; e.rstn = 1'b1; e.valid = 1'b0; e.ready = 1'b0;
    e.z = 1'($urandom_range(0, 1)); e.rdata = $urandom;
    e.imem_req = 0; e.dmem_req = 0; e.dmem_we = 0; e.pc_wen = 0; e.rf_wen = 0;
    e.retire = 0; e.calc = 0; e.jalr = 0; e.imm_sel = 0; e.illegal = 0;
    e.alu_op = '0; e.wb_sel = '0; e.instr = 32'h0000_0013;
    e.c_rst = 0; e.c_rstval = 0; e.c_instr = 0; e.c_alu = 0; e.c_imm = 0; e.c_wb = 0; e.c_fin = 0;
    return e;
  endfunction

  function automatic string kind_of(input logic [31:0] i);
    case (i[6:0])
      7'h33: return "op";
      7'h13: return "opimm";
      7'h03: return "load";
      7'h23: return "store";
      7'h63: return "branch";
      7'h6F: return "jal";
      7'h67: return "jalr";
      7'h37: return "lui";
      7'h17: return "auipc";
      7'h73, 7'h0F: return "nop";
`ifdef SEQ_ILLEGAL_TRAP_EN
      default: return "illegal";
`else
      default: return "nop";
`endif
    endcase
  endfunction

  // ALU op from the mnemonic table: R-type/I-type use funct fields, branches map by comparison kind.
  function automatic logic [3:0] exp_alu(input logic [31:0] i);
    string k;
    logic [2:0] f3;
    k = kind_of(i);
    f3 = i[14:12];
    if (k == "op") return {i[30], f3};
    if (k == "opimm") return {(f3 == 3'd5) ? i[30] : 1'b0, f3};
    if (k == "branch") begin
      if (f3 == 3'd4 || f3 == 3'd5) return 4'b0010;
      if (f3 == 3'd6 || f3 == 3'd7) return 4'b0011;
      return 4'b1000;
    end
    return 4'b0000;
  endfunction

  function automatic bit branch_taken(input logic [2:0] f3, input bit z);
    case (f3)
      3'd0, 3'd5, 3'd7: return z;   // BEQ, BGE, BGEU
      default:          return !z;  // BNE, BLT, BLTU
    endcase
  endfunction

  function automatic logic [1:0] exp_wb(input string k);
    if (k == "load") return 2'd1;
    if (k == "jal" || k == "jalr") return 2'd2;
    if (k == "lui") return 2'd3;
    return 2'd0;
  endfunction

  // zx: 0/1 forces i_alu_z in EXECUTE, anything else leaves it random.
  task automatic build(input logic [31:0] ins, input int wf, input int wd, input int zx, input bit after_rst);
    string k;
    cyc_t  e;
    k = kind_of(ins);
    for (int c = 0; c <= wf; c++) begin
      e = blank("fetch");
      e.imem_req = 1'b1;
      if (c == wf) begin e.valid = 1'b1; e.rdata = ins; end
      if (c == 0 && after_rst) e.c_rstval = 1'b1;
      plan.push_back(e);
    end
    e = blank("decode"); e.instr = ins; e.c_instr = 1'b1;
    plan.push_back(e);
    e = blank("execute"); e.instr = ins; e.c_instr = 1'b1; e.c_alu = 1'b1;
    e.alu_op = exp_alu(ins);
    if (zx == 0 || zx == 1) e.z = zx[0];
    if (k == "op" || k == "branch") begin e.c_imm = 1'b1; e.imm_sel = 1'b0; end
    if (k == "opimm" || k == "load" || k == "store" || k == "jalr" || k == "auipc") begin
      e.c_imm = 1'b1; e.imm_sel = 1'b1;
    end
    if (k == "branch" || k == "nop") begin
      e.pc_wen = 1'b1; e.retire = 1'b1; e.c_fin = 1'b1;
      e.calc = (k == "branch") && branch_taken(ins[14:12], e.z);
      plan.push_back(e);
      return;
    end
    plan.push_back(e);
    if (k == "load" || k == "store") begin
      for (int c = 0; c <= wd; c++) begin
        e = blank("memory"); e.instr = ins; e.c_instr = 1'b1;
        e.dmem_req = 1'b1; e.dmem_we = (k == "store"); e.ready = (c == wd);
        if (c == wd && k == "store") begin e.pc_wen = 1'b1; e.retire = 1'b1; e.c_fin = 1'b1; end
        plan.push_back(e);
      end
      if (k == "store") return;
    end
    e = blank("writeback"); e.instr = ins; e.c_instr = 1'b1; e.c_fin = 1'b1; e.c_wb = 1'b1;
    e.rf_wen = (ins[11:7] != 5'd0); e.pc_wen = 1'b1; e.retire = 1'b1;
    e.wb_sel = exp_wb(k); e.calc = (k == "jal"); e.jalr = (k == "jalr");
    plan.push_back(e);
  endtask

  task automatic push_reset();
    cyc_t e;
    e = blank("reset"); e.rstn = 1'b0; e.c_rst = 1'b1; e.valid = 1'b1; e.ready = 1'b1;
    plan.push_back(e);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int unsigned pick;
    r = $urandom;
    pick = $urandom_range(0, 10);
    case (pick)
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h03;
      3: r[6:0] = 7'h23;
      4: begin r[6:0] = 7'h63; if (!r[14]) r[13] = 1'b0; end
      5: r[6:0] = 7'h6F;
      6: r[6:0] = 7'h67;
      7: r[6:0] = 7'h37;
      8: r[6:0] = 7'h17;
      9: r[6:0] = r[31] ? 7'h73 : 7'h0F;
`ifdef SEQ_ILLEGAL_TRAP_EN
      default: r[6:0] = 7'h33;
`else
      default: r[6:0] = r[31] ? 7'h7F : 7'h0B;
`endif
    endcase
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (plan.size() > 0) begin
        cur = plan.pop_front();
        cur_ok = 1'b1;
        rstn = cur.rstn; imem_valid = cur.valid; imem_rdata = cur.rdata;
        dmem_ready = cur.ready; alu_z = cur.z;
      end else begin
        cur_ok = 1'b0;
        rstn = 1'b1; imem_valid = 1'b0; dmem_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cur_ok) begin
      stage = cur.tag;
      chk("pc_wen", 32'(pc_wen), 32'(cur.pc_wen));
      chk("rf_wen", 32'(rf_wen), 32'(cur.rf_wen));
      chk("retire", 32'(retire), 32'(cur.retire));
      if (!cur.c_rst) begin
        chk("imem_req", 32'(imem_req), 32'(cur.imem_req));
        chk("dmem_req", 32'(dmem_req), 32'(cur.dmem_req));
        chk("illegal", 32'(illegal), 32'(cur.illegal));
        if (cur.dmem_req) chk("dmem_we", 32'(dmem_we), 32'(cur.dmem_we));
      end
      if (cur.c_rstval) begin
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_alu_op", 32'(alu_op), 32'h0);
        chk("rst_wb_sel", 32'(wb_sel), 32'h0);
        chk("rst_imm_sel", 32'(imm_sel), 32'h0);
      end
      if (cur.c_instr) chk("instr", instr, cur.instr);
      if (cur.c_alu) chk("alu_op", 32'(alu_op), 32'(cur.alu_op));
      if (cur.c_imm) chk("imm_sel", 32'(imm_sel), 32'(cur.imm_sel));
      if (cur.c_wb) chk("wb_sel", 32'(wb_sel), 32'(cur.wb_sel));
      if (cur.c_fin) begin
        chk("calc_bj_addr", 32'(calc_bj_addr), 32'(cur.calc));
        chk("jalr_sel", 32'(jalr_sel), 32'(cur.jalr));
      end
    end
  end

  initial begin
    int b;
    int wf, wd;
    bit pend_rst;
    logic [31:0] ins;
    cyc_t e;

    push_reset();
    push_reset();

    // add x3,x1,x2
    b = plan.size();
    build(32'h0020_81B3, 0, 0, 2, 1'b1);
    chk("add.len", 32'(plan.size() - b), 32'd4);
    chk("add.alu_op", 32'(plan[b+2].alu_op), 32'h0);
    chk("add.rf_wen", 32'(plan[b+3].rf_wen), 32'd1);
    chk("add.pc_wen", 32'(plan[b+3].pc_wen), 32'd1);
    chk("add.calc", 32'(plan[b+3].calc), 32'd0);

    // beq x1,x2,+8 taken, then not taken
    b = plan.size();
    build(32'h0020_8463, 0, 0, 1, 1'b0);
    chk("beq1.len", 32'(plan.size() - b), 32'd3);
    chk("beq1.alu_op", 32'(plan[b+2].alu_op), 32'b1000);
    chk("beq1.calc", 32'(plan[b+2].calc), 32'd1);
    b = plan.size();
    build(32'h0020_8463, 0, 0, 0, 1'b0);
    chk("beq0.calc", 32'(plan[b+2].calc), 32'd0);

    // lw x5,0(x1) with two wait cycles
    b = plan.size();
    build(32'h0000_A283, 0, 2, 2, 1'b0);
    chk("lw.len", 32'(plan.size() - b), 32'd7);
    chk("lw.req_last", 32'(plan[b+5].dmem_req), 32'd1);
    chk("lw.wb_sel", 32'(plan[b+6].wb_sel), 32'd1);

    // jal x1,+8
    b = plan.size();
    build(32'h0080_00EF, 0, 0, 2, 1'b0);
    chk("jal.wb_sel", 32'(plan[b+3].wb_sel), 32'd2);
    chk("jal.calc", 32'(plan[b+3].calc), 32'd1);

    // sw x2,0(x1): reset lands in its second MEMORY cycle, with ready and imem valid pending
    build(32'h0020_A023, 0, 3, 2, 1'b0);
    repeat (3) void'(plan.pop_back());
    push_reset();
    pend_rst = 1'b1;

`ifdef SEQ_ILLEGAL_TRAP_EN
    b = plan.size();
    e = blank("fetch"); e.imem_req = 1'b1; e.valid = 1'b1; e.rdata = 32'h0000_007F;
    if (pend_rst) e.c_rstval = 1'b1;
    plan.push_back(e);
    e = blank("decode"); e.instr = 32'h0000_007F; e.c_instr = 1'b1;
    plan.push_back(e);
    for (int t = 0; t < 10; t++) begin
      e = blank("trap"); e.illegal = 1'b1; e.valid = 1'b1; e.ready = 1'b1;
      e.instr = 32'h0000_007F; e.c_instr = 1'b1;
      plan.push_back(e);
    end
    push_reset();
    pend_rst = 1'b1;
`else
    b = plan.size();
    build(32'h0000_007F, 0, 0, 2, pend_rst);
    pend_rst = 1'b0;
    chk("ill.len", 32'(plan.size() - b), 32'd3);
    chk("ill.pc_wen", 32'(plan[b+2].pc_wen), 32'd1);
`endif

    for (int n = 0; n < 250; n++) begin
      ins = rand_instr();
      wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      wd = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      build(ins, wf, wd, 2, pend_rst);
      pend_rst = 1'b0;
    end

    for (int t = 0; t < 20000 && plan.size() > 0; t++) @(posedge clk);
    stage = "drain";
    chk("plan_drained", 32'(plan.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
